// File: rtl/truth_table_checker.sv
// -----------------------------------------------------------------------------
// truth_table_checker
//
// Response-side checker for 3-input / 1-output combinational blocks. Each cycle
// that vld is high during a run, the applied vector idx = {A,B,C} (A = MSB) and
// the observed output Y are sampled. Y is compared against the EXPECTED truth
// table (bit i = expected Y for idx i). The checker also tracks which of the
// eight input combinations have been seen. A run ends when all eight are
// covered or when TIMEOUT cycles pass with no vld, and the result is then
// reported.
//
// Parameters
//   EXPECTED  expected Y per idx (default 8'hD5 = (A&B)|~C)
//   TIMEOUT   idle cycles in a run before a forced finish (>= 2)
//
// Optional feature (compile-time macro)
//   CHK_ORDER_EN  when defined, samples must also arrive in ascending idx
//                 order 0..7. An out-of-sequence sample counts as a mismatch
//                 even when Y is correct. The expected-next pointer advances
//                 only on an in-order sample. When undefined, order is not
//                 checked and the pointer logic is not built.
//
// Ports
//   clk             in   1  clock, all logic on posedge
//   reset           in   1  synchronous, active-high
//   start           in   1  begin a run (honoured when not busy)
//   vld             in   1  A,B,C,Y valid this cycle
//   A, B, C         in   1  applied input vector
//   Y               in   1  DUT output for that vector
//   busy            out  1  high while a run is in progress
//   done            out  1  run finished; sticky until next start or reset
//   pass            out  1  valid with done: no mismatches and full coverage
//   err_cnt         out  4  mismatch count, saturating at 15
//   cov             out  8  bit i set once idx i has been sampled
//   first_fail_idx  out  3  idx of the first mismatch of the run
//   first_fail_vld  out  1  first_fail_idx is meaningful
// -----------------------------------------------------------------------------
module truth_table_checker #(
  parameter logic [7:0] EXPECTED = 8'hD5,
  parameter int         TIMEOUT  = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       vld,
  input  logic       A,
  input  logic       B,
  input  logic       C,
  input  logic       Y,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_cnt,
  output logic [7:0] cov,
  output logic [2:0] first_fail_idx,
  output logic       first_fail_vld
);

  // Run states
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CHECK = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  // The idle timer only needs to reach TIMEOUT-1
  localparam int                  TIMER_W    = $clog2(TIMEOUT);
  localparam logic [TIMER_W-1:0]  TIMER_LAST = TIMER_W'(TIMEOUT - 1);
  localparam logic [TIMER_W-1:0]  TIMER_ONE  = TIMER_W'(1);

  // Saturating 4-bit increment for the mismatch counter
  function automatic logic [3:0] sat_inc4(input logic [3:0] val);
    logic [3:0] res;
    if (val == 4'hF) begin
      res = 4'hF;
    end else begin
      res = val + 4'd1;
    end
    return res;
  endfunction

  // State and registered outputs
  logic [1:0]         state_r;
  logic [TIMER_W-1:0] timer_r;
  logic               busy_r;
  logic               done_r;
  logic               pass_r;
  logic [3:0]         err_cnt_r;
  logic [7:0]         cov_r;
  logic [2:0]         ff_idx_r;
  logic               ff_vld_r;

  // Next-state values
  logic [1:0]         state_s;
  logic [TIMER_W-1:0] timer_s;
  logic               busy_s;
  logic               done_s;
  logic               pass_s;
  logic [3:0]         err_cnt_s;
  logic [7:0]         cov_s;
  logic [2:0]         ff_idx_s;
  logic               ff_vld_s;

  // Sample decode helpers
  logic [2:0] idx_s;
  logic       y_exp_s;
  logic       order_err_s;
  logic       mismatch_s;
  logic [7:0] cov_upd_s;
  logic [3:0] err_upd_s;
  logic       enter_check_s;
  logic       sample_s;

  // Decode the current sample and precompute its effect on coverage/errors
  always_comb begin
    idx_s         = {A, B, C};
    y_exp_s       = EXPECTED[idx_s];
    mismatch_s    = (Y != y_exp_s) | order_err_s;
    cov_upd_s     = cov_r | (8'b0000_0001 << idx_s);
    if (mismatch_s) begin
      err_upd_s = sat_inc4(err_cnt_r);
    end else begin
      err_upd_s = err_cnt_r;
    end
    // start is only honoured outside a run; vld in that same cycle is dropped
    enter_check_s = start && ((state_r == ST_IDLE) || (state_r == ST_DONE));
    sample_s      = vld && (state_r == ST_CHECK);
  end

`ifdef CHK_ORDER_EN
  logic [2:0] next_idx_r;

  // Flag a sample whose idx is not the next one in ascending order
  always_comb begin
    if (idx_s != next_idx_r) begin
      order_err_s = 1'b1;
    end else begin
      order_err_s = 1'b0;
    end
  end

  // Expected-next pointer: restarts with each run, advances on in-order samples
  always_ff @(posedge clk) begin
    if (reset) begin
      next_idx_r <= 3'd0;
    end else if (enter_check_s) begin
      next_idx_r <= 3'd0;
    end else if (sample_s && !order_err_s) begin
      next_idx_r <= next_idx_r + 3'd1;
    end else begin
      next_idx_r <= next_idx_r;
    end
  end
`else
  // Order is not checked in this build
  always_comb begin
    order_err_s = 1'b0;
  end
`endif

  // Run control: next state, timer and result registers
  always_comb begin
    state_s   = state_r;
    timer_s   = timer_r;
    busy_s    = busy_r;
    done_s    = done_r;
    pass_s    = pass_r;
    err_cnt_s = err_cnt_r;
    cov_s     = cov_r;
    ff_idx_s  = ff_idx_r;
    ff_vld_s  = ff_vld_r;

    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (enter_check_s) begin
          // A new run wipes the previous result
          state_s   = ST_CHECK;
          timer_s   = '0;
          busy_s    = 1'b1;
          done_s    = 1'b0;
          pass_s    = 1'b0;
          err_cnt_s = 4'd0;
          cov_s     = 8'h00;
          ff_idx_s  = 3'd0;
          ff_vld_s  = 1'b0;
        end else begin
          state_s = state_r;
        end
      end

      ST_CHECK: begin
        if (vld) begin
          // A sample always wins over a timeout in the same cycle
          timer_s   = '0;
          cov_s     = cov_upd_s;
          err_cnt_s = err_upd_s;
          if (mismatch_s && !ff_vld_r) begin
            ff_idx_s = idx_s;
            ff_vld_s = 1'b1;
          end else begin
            ff_idx_s = ff_idx_r;
          end
          // Completing sample's own update is folded into the verdict
          if (cov_upd_s == 8'hFF) begin
            state_s = ST_DONE;
            busy_s  = 1'b0;
            done_s  = 1'b1;
            pass_s  = (err_upd_s == 4'd0);
          end else begin
            state_s = ST_CHECK;
          end
        end else if (timer_r == TIMER_LAST) begin
          // Stalled run: report failure, keep coverage and errors as they are
          state_s = ST_DONE;
          busy_s  = 1'b0;
          done_s  = 1'b1;
          pass_s  = 1'b0;
        end else begin
          timer_s = timer_r + TIMER_ONE;
        end
      end

      default: begin
        // Unreachable encoding: fall back to a clean idle
        state_s   = ST_IDLE;
        timer_s   = '0;
        busy_s    = 1'b0;
        done_s    = 1'b0;
        pass_s    = 1'b0;
        err_cnt_s = 4'd0;
        cov_s     = 8'h00;
        ff_idx_s  = 3'd0;
        ff_vld_s  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      timer_r   <= '0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      pass_r    <= 1'b0;
      err_cnt_r <= 4'd0;
      cov_r     <= 8'h00;
      ff_idx_r  <= 3'd0;
      ff_vld_r  <= 1'b0;
    end else begin
      state_r   <= state_s;
      timer_r   <= timer_s;
      busy_r    <= busy_s;
      done_r    <= done_s;
      pass_r    <= pass_s;
      err_cnt_r <= err_cnt_s;
      cov_r     <= cov_s;
      ff_idx_r  <= ff_idx_s;
      ff_vld_r  <= ff_vld_s;
    end
  end

  assign busy           = busy_r;
  assign done           = done_r;
  assign pass           = pass_r;
  assign err_cnt        = err_cnt_r;
  assign cov            = cov_r;
  assign first_fail_idx = ff_idx_r;
  assign first_fail_vld = ff_vld_r;

endmodule

// File: tb/tb_truth_table_checker.sv
module tb_truth_table_checker;

  localparam int TIMEOUT = 64;

  logic       clk;
  logic       rst_d, start_d, vld_d, y_d;
  logic [2:0] idx_d;
  logic       busy, done, pass, first_fail_vld;
  logic [3:0] err_cnt;
  logic [7:0] cov;
  logic [2:0] first_fail_idx;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  truth_table_checker #(.EXPECTED(8'hD5), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(rst_d), .start(start_d), .vld(vld_d),
    .A(idx_d[2]), .B(idx_d[1]), .C(idx_d[0]), .Y(y_d),
    .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt), .cov(cov),
    .first_fail_idx(first_fail_idx), .first_fail_vld(first_fail_vld)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference truth table written from the boolean rule Y = (A&B)|~C
  function automatic bit ref_y(input int idx);
    bit a, b, c;
    a = idx[2]; b = idx[1]; c = idx[0];
    return (a & b) | ~c;
  endfunction

  // Behavioural reference model: a run is "active" or not, with a set of seen
  // combinations, an unbounded error count and an idle-cycle counter.
  bit m_active, m_done, m_pass, m_ffv;
  bit m_seen[8];
  int m_err, m_ffi, m_idle, m_nexp;

  function automatic int m_cov();
    int v = 0;
    for (int i = 0; i < 8; i++) if (m_seen[i]) v += (1 << i);
    return v;
  endfunction

  function automatic bit m_all_seen();
    for (int i = 0; i < 8; i++) if (!m_seen[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_update();
    bit bad;
    int idx;
    idx = int'(idx_d);
    if (rst_d) begin
      m_active = 0; m_done = 0; m_pass = 0; m_err = 0; m_ffi = 0; m_ffv = 0;
      m_idle = 0; m_nexp = 0;
      for (int i = 0; i < 8; i++) m_seen[i] = 0;
    end else if (!m_active) begin
      if (start_d) begin
        m_active = 1; m_done = 0; m_pass = 0; m_err = 0; m_ffi = 0; m_ffv = 0;
        m_idle = 0; m_nexp = 0;
        for (int i = 0; i < 8; i++) m_seen[i] = 0;
      end
    end else if (vld_d) begin
      bad = (y_d != ref_y(idx));
`ifdef CHK_ORDER_EN
      if (idx != m_nexp) bad = 1;
      else m_nexp = m_nexp + 1;
`endif
      m_seen[idx] = 1;
      m_idle = 0;
      if (bad) begin
        m_err++;
        if (!m_ffv) begin m_ffv = 1; m_ffi = idx; end
      end
      if (m_all_seen()) begin
        m_active = 0; m_done = 1; m_pass = (m_err == 0);
      end
    end else begin
      m_idle++;
      if (m_idle == TIMEOUT) begin
        m_active = 0; m_done = 1; m_pass = 0;
      end
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  // One clock: model consumes the driven inputs at the edge, then the DUT is
  // compared against the model just after the edge.
  task automatic step();
    @(posedge clk);
    model_update();
    cyc++;
    #1;
    chk("busy",    busy,           m_active);
    chk("done",    done,           m_done);
    chk("pass",    pass,           m_pass);
    chk("err_cnt", err_cnt,        (m_err > 15) ? 15 : m_err);
    chk("cov",     cov,            m_cov());
    chk("ff_vld",  first_fail_vld, m_ffv);
    chk("ff_idx",  first_fail_idx, m_ffi);
  endtask

  task automatic idle_in();
    rst_d = 0; start_d = 0; vld_d = 0; idx_d = 3'd0; y_d = 1'b0;
  endtask

  task automatic do_start();
    idle_in(); start_d = 1; step(); idle_in();
  endtask

  task automatic sample(input int idx, input bit flip);
    idle_in(); vld_d = 1; idx_d = 3'(idx); y_d = ref_y(idx) ^ flip; step(); idle_in();
  endtask

  task automatic idle_cycles(input int n);
    idle_in();
    for (int i = 0; i < n; i++) step();
  endtask

  // Wait (bounded) for done; returns the number of cycles taken
  task automatic wait_done(input int limit, output int took);
    took = 0;
    idle_in();
    while (done !== 1'b1 && took < limit) begin step(); took++; end
    if (done !== 1'b1) chk("wait_done_timeout", 0, 1);
  endtask

  typedef struct {
    string      name;
    logic [7:0] flip;
    int         gap;
    bit         exp_pass;
    int         exp_err;
    bit         exp_ffv;
    int         exp_ffi;
  } vec_t;

  vec_t tbl[5];
  int   took;
  int   order6[8];
  int   burst;

  initial begin
    tbl[0] = '{"t1_clean",   8'h00, 20, 1'b1, 0, 1'b0, 0};
    tbl[1] = '{"t2_idx5_6",  8'h60, 20, 1'b0, 2, 1'b1, 5};
    tbl[2] = '{"all_wrong",  8'hFF, 1,  1'b0, 8, 1'b1, 0};
    tbl[3] = '{"last_wrong", 8'h80, 3,  1'b0, 1, 1'b1, 7};
    tbl[4] = '{"first_wrong",8'h01, 1,  1'b0, 1, 1'b1, 0};
    order6 = '{0, 1, 3, 2, 4, 5, 6, 7};

    idle_in();
    rst_d = 1; step(); step();
    chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk("rst_pass", pass, 0);
    chk("rst_err", err_cnt, 0); chk("rst_cov", cov, 0);
    chk("rst_ffi", first_fail_idx, 0); chk("rst_ffv", first_fail_vld, 0);
    idle_in();

    // Table-driven ascending sweeps
    foreach (tbl[k]) begin
      do_start();
      chk({tbl[k].name, "_busy_on_start"}, busy, 1);
      for (int i = 0; i < 8; i++) begin
        sample(i, tbl[k].flip[i]);
        if (i < 7) idle_cycles(tbl[k].gap - 1);
      end
      chk({tbl[k].name, "_done"}, done, 1);
      chk({tbl[k].name, "_busy"}, busy, 0);
      chk({tbl[k].name, "_pass"}, pass, tbl[k].exp_pass);
      chk({tbl[k].name, "_err"},  err_cnt, tbl[k].exp_err);
      chk({tbl[k].name, "_cov"},  cov, 8'hFF);
      chk({tbl[k].name, "_ffv"},  first_fail_vld, tbl[k].exp_ffv);
      if (tbl[k].exp_ffv) chk({tbl[k].name, "_ffi"}, first_fail_idx, tbl[k].exp_ffi);
      idle_cycles(3);
      chk({tbl[k].name, "_done_sticky"}, done, 1);
      chk({tbl[k].name, "_pass_held"}, pass, tbl[k].exp_pass);
    end

    // T3: partial sweep, done exactly TIMEOUT cycles after the last sample
    do_start();
    for (int i = 0; i < 7; i++) begin sample(i, 1'b0); idle_cycles(19); end
    // the last sample edge was 19 idle steps ago
    wait_done(200, took);
    chk("t3_latency", took + 19, TIMEOUT);
    chk("t3_pass", pass, 0); chk("t3_cov", cov, 8'h7F); chk("t3_err", err_cnt, 0);

    // T4: 20 mismatches cycling idx 0..3, saturation and timeout
    do_start();
    for (int i = 0; i < 20; i++) begin sample(i % 4, 1'b1); idle_cycles(1); end
    chk("t4_err_sat", err_cnt, 15); chk("t4_cov", cov, 8'h0F); chk("t4_busy", busy, 1);
    wait_done(200, took);
    chk("t4_pass", pass, 0); chk("t4_ffi", first_fail_idx, 0); chk("t4_err_kept", err_cnt, 15);

    // T5: reset mid-run, then a clean sweep
    do_start();
    for (int i = 0; i < 4; i++) sample(i, i == 2);
    rst_d = 1; step(); idle_in();
    chk("t5_busy", busy, 0); chk("t5_cov", cov, 0); chk("t5_err", err_cnt, 0);
    chk("t5_ffv", first_fail_vld, 0); chk("t5_done", done, 0);
    do_start();
    for (int i = 0; i < 8; i++) sample(i, 1'b0);
    chk("t5_pass", pass, 1); chk("t5_done2", done, 1);

    // T6: swapped 3/2 order with correct Y
    do_start();
    for (int i = 0; i < 8; i++) sample(order6[i], 1'b0);
    chk("t6_done", done, 1);
`ifdef CHK_ORDER_EN
    chk("t6_pass", pass, 0); chk("t6_ffi", first_fail_idx, 3); chk("t6_ffv", first_fail_vld, 1);
`else
    chk("t6_pass", pass, 1); chk("t6_err", err_cnt, 0);
`endif

    // Start with vld in the same cycle: the sample must be dropped
    idle_in(); start_d = 1; vld_d = 1; idx_d = 3'd4; y_d = 1'b1; step(); idle_in();
    chk("start_vld_cov", cov, 0);
    // start while busy is ignored
    sample(0, 1'b0); start_d = 1; step(); idle_in();
    chk("start_busy_cov", cov, 8'h01);

    // Randomized traffic checked cycle by cycle against the model
    burst = 0;
    for (int n = 0; n < 5000; n++) begin
      idle_in();
      rst_d   = ($urandom_range(0, 999) < 2);
      start_d = ($urandom_range(0, 99) < 6);
      if (burst > 0) begin
        burst--;
      end else if ($urandom_range(0, 99) < 2) begin
        burst = $urandom_range(TIMEOUT - 8, TIMEOUT + 8);
      end else begin
        vld_d = ($urandom_range(0, 1) == 1);
      end
      idx_d = 3'($urandom_range(0, 7));
      y_d   = ref_y(int'(idx_d)) ^ ($urandom_range(0, 9) == 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
